fsic_is_rx_fifo: RTL and testbench

Receive-side elastic buffer directly downstream of the IO serdes Rx path. The serdes presents one de-serialised AXIS beat per axis_clk with no backpressure (is_as_tvalid only). This block stores each beat in a FIFO and replays it to the axis switch through a standard valid/ready AXIS master. It also generates the as_is_tready flow-control bit that the serdes Tx path carries to the remote side, so the remote side stops sending before this FIFO overflows.

---
 rtl/fsic_is_rx_fifo.sv | 126 ++++++++++++
 tb/tb_fsic_is_rx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fsic_is_rx_fifo.sv
// Rx elastic buffer between serdes Rx (no backpressure) and the axis switch; first-word fall-through, 1-cycle write-to-read latency.
// Downstream honours m_tready; upstream is throttled only through as_is_tready, and beats arriving while full are dropped and flagged.
module fsic_is_rx_fifo #(
  parameter int pDATA_WIDTH     = 32,
  parameter int pFIFO_DEPTH     = 16,
  parameter int pFREE_THRESHOLD = 6
) (
  input  logic                               axis_clk,
  input  logic                               axis_rst,
  input  logic [pDATA_WIDTH-1:0]             is_as_tdata,
  input  logic [pDATA_WIDTH/8-1:0]           is_as_tstrb,
  input  logic [pDATA_WIDTH/8-1:0]           is_as_tkeep,
  input  logic                               is_as_tlast,
  input  logic [1:0]                         is_as_tid,
  input  logic [1:0]                         is_as_tuser,
  input  logic                               is_as_tvalid,
  output logic [pDATA_WIDTH-1:0]             m_tdata,
  output logic [pDATA_WIDTH/8-1:0]           m_tstrb,
  output logic [pDATA_WIDTH/8-1:0]           m_tkeep,
  output logic                               m_tlast,
  output logic [1:0]                         m_tid,
  output logic [1:0]                         m_tuser,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               as_is_tready,
  output logic [$clog2(pFIFO_DEPTH):0]       fifo_count,
  output logic                               overflow,
  input  logic                               clr_overflow
);

  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = pDATA_WIDTH / 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(pFIFO_DEPTH);
  localparam logic [CW-1:0] THR_C   = CW'(pFREE_THRESHOLD);

  typedef struct packed {
    logic                   tlast;
    logic [1:0]             tid;
    logic [1:0]             tuser;
    logic [SW-1:0]          tkeep;
    logic [SW-1:0]          tstrb;
    logic [pDATA_WIDTH-1:0] tdata;
  } entry_t;

  entry_t          mem [pFIFO_DEPTH];
  entry_t          wr_entry;
  entry_t          rd_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   free_next;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;

  assign full = (count == DEPTH_C);
  assign pop  = m_tvalid && m_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = is_as_tvalid && (!full || pop);
  assign drop = is_as_tvalid && full && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
    free_next = DEPTH_C - count_next;
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.tlast = is_as_tlast;
    wr_entry.tid   = is_as_tid;
    wr_entry.tuser = is_as_tuser;
    wr_entry.tkeep = is_as_tkeep;
    wr_entry.tstrb = is_as_tstrb;
    wr_entry.tdata = is_as_tdata;
  end

  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      as_is_tready <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count        <= count_next;
      // Threshold leaves room for beats already in flight over the serdes loop.
      as_is_tready <= (free_next > THR_C);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign rd_entry   = mem[rd_ptr];
  assign m_tvalid   = (count != '0);
  assign m_tdata    = rd_entry.tdata;
  assign m_tstrb    = rd_entry.tstrb;
  assign m_tkeep    = rd_entry.tkeep;
  assign m_tlast    = rd_entry.tlast;
  assign m_tid      = rd_entry.tid;
  assign m_tuser    = rd_entry.tuser;
  assign fifo_count = count;

endmodule

// File: tb/tb_fsic_is_rx_fifo.sv
// Bench for fsic_is_rx_fifo: directed stimulus, expected beats queued by the driver and checked by an output monitor.
module tb_fsic_is_rx_fifo;

  logic        axis_clk;
  logic        axis_rst;
  logic [31:0] is_as_tdata;
  logic [3:0]  is_as_tstrb;
  logic [3:0]  is_as_tkeep;
  logic        is_as_tlast;
  logic [1:0]  is_as_tid;
  logic [1:0]  is_as_tuser;
  logic        is_as_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tid;
  logic [1:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic        as_is_tready;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  k;
    logic        l;
    logic [1:0]  id;
    logic [1:0]  u;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  fsic_is_rx_fifo #(
    .pDATA_WIDTH(32), .pFIFO_DEPTH(16), .pFREE_THRESHOLD(6)
  ) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .is_as_tdata(is_as_tdata), .is_as_tstrb(is_as_tstrb), .is_as_tkeep(is_as_tkeep),
    .is_as_tlast(is_as_tlast), .is_as_tid(is_as_tid), .is_as_tuser(is_as_tuser),
    .is_as_tvalid(is_as_tvalid),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .as_is_tready(as_is_tready), .fifo_count(fifo_count),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                       input logic l, input logic [1:0] id, input logic [1:0] u,
                       input bit accepted);
    beat_t b;
    is_as_tdata  = d;
    is_as_tstrb  = s;
    is_as_tkeep  = k;
    is_as_tlast  = l;
    is_as_tid    = id;
    is_as_tuser  = u;
    is_as_tvalid = 1'b1;
    if (accepted) begin
      b.d = d; b.s = s; b.k = k; b.l = l; b.id = id; b.u = u;
      exp_q.push_back(b);
    end
  endtask

  // Output monitor: every handshake must match the oldest expected beat.
  always @(negedge axis_clk) begin
    if (!axis_rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got tdata 0x%0h with empty scoreboard", m_tdata);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_tdata", m_tdata, e.d);
        check("beat_tstrb", 32'(m_tstrb), 32'(e.s));
        check("beat_tkeep", 32'(m_tkeep), 32'(e.k));
        check("beat_meta", {27'd0, m_tlast, m_tid, m_tuser}, {27'd0, e.l, e.id, e.u});
      end
    end
  end

  initial begin
    axis_rst     = 1'b0;
    is_as_tdata  = '0;
    is_as_tstrb  = '0;
    is_as_tkeep  = '0;
    is_as_tlast  = 1'b0;
    is_as_tid    = '0;
    is_as_tuser  = '0;
    is_as_tvalid = 1'b0;
    m_tready     = 1'b0;
    clr_overflow = 1'b0;
    #2 axis_rst = 1'b1;
    tick();
    tick();
    check("in_reset_tvalid", 32'(m_tvalid), 32'd0);
    check("in_reset_tready", 32'(as_is_tready), 32'd0);
    axis_rst = 1'b0;
    tick();
    check("rst_rel_tready", 32'(as_is_tready), 32'd1);
    check("rst_rel_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_rel_count", 32'(fifo_count), 32'd0);
    check("rst_rel_ovf", 32'(overflow), 32'd0);

    // Single beat with consumer ready.
    m_tready = 1'b1;
    drive(32'hA5A5_0001, 4'hF, 4'hF, 1'b1, 2'd2, 2'd1, 1'b1);
    check("single_pre_tvalid", 32'(m_tvalid), 32'd0);
    tick();
    is_as_tvalid = 1'b0;
    check("single_tvalid", 32'(m_tvalid), 32'd1);
    check("single_count1", 32'(fifo_count), 32'd1);
    tick();
    check("single_count0", 32'(fifo_count), 32'd0);
    check("single_tvalid0", 32'(m_tvalid), 32'd0);

    // Fill with consumer stalled; tready low once free space is 6 or less.
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(32'(i), 4'(i), 4'hF, (i % 4) == 3, 2'(i), 2'(i + 1), 1'b1);
      tick();
      check("fill_count", 32'(fifo_count), 32'(i + 1));
      check("fill_tready", 32'(as_is_tready), (i + 1 <= 9) ? 32'd1 : 32'd0);
    end
    check("full_ovf0", 32'(overflow), 32'd0);

    // Beat arriving while full is dropped.
    drive(32'hDEAD_BEEF, 4'h5, 4'h5, 1'b1, 2'd3, 2'd3, 1'b0);
    tick();
    is_as_tvalid = 1'b0;
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(fifo_count), 32'd16);

    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Clear coinciding with a drop: set wins.
    drive(32'hBAD0_0001, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0);
    clr_overflow = 1'b1;
    tick();
    is_as_tvalid = 1'b0;
    clr_overflow = 1'b0;
    check("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    check("clr_vs_drop_count", 32'(fifo_count), 32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_again_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop across pointer wrap.
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(32'(100 + i), 4'hF, 4'hC, 1'b0, 2'd1, 2'd2, 1'b1);
      tick();
      check("stream_count", 32'(fifo_count), 32'd16);
    end
    is_as_tvalid = 1'b0;
    check("stream_ovf", 32'(overflow), 32'd0);
    check("stream_tready", 32'(as_is_tready), 32'd0);

    for (int i = 0; i < 16; i++) tick();
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_tready", 32'(as_is_tready), 32'd1);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset while holding 7 entries.
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(32'h7000 + 32'(i), 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 1'b1);
      tick();
    end
    is_as_tvalid = 1'b0;
    check("hold7_count", 32'(fifo_count), 32'd7);
    axis_rst = 1'b1;
    #1;
    check("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_tready", 32'(as_is_tready), 32'd0);
    exp_q.delete();
    tick();
    axis_rst = 1'b0;
    tick();
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("post_rst_tready", 32'(as_is_tready), 32'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
